// File: rtl/sm3_compress_if.sv
// ---------------------------------------------------------------------------
// sm3_compress_if
//   Bundles the start handshake, the dual read port into the message
//   expansion stage and the hash result of the SM3 compression stage.
//
//   master : upstream/expansion side (drives start, first, extend_valid and
//            the read data returned for the requested addresses)
//   slave  : compression core (drives read addresses, ready, hash, valid)
//
//   i_start        pulse, schedule for one block is ready
//   i_first        sampled with i_start, 1 = first block of a message
//   i_extend_valid expansion stage holds a complete W/W' schedule
//   o_rd_addr0     W_j address
//   o_rd_addr1     W'_j address
//   i_rd_data0     W_j, combinational from o_rd_addr0
//   i_rd_data1     W'_j, combinational from o_rd_addr1
//   o_ready        core idle, start accepted
//   o_hash         current V, A in [255:224] ... H in [31:0]
//   o_hash_valid   one-cycle pulse when o_hash updates
// ---------------------------------------------------------------------------
interface sm3_compress_if #(
  parameter int ADDR_W = 8
);
  logic              i_start;
  logic              i_first;
  logic              i_extend_valid;
  logic [ADDR_W-1:0] o_rd_addr0;
  logic [ADDR_W-1:0] o_rd_addr1;
  logic [31:0]       i_rd_data0;
  logic [31:0]       i_rd_data1;
  logic              o_ready;
  logic [255:0]      o_hash;
  logic              o_hash_valid;

  modport master (
    output i_start, i_first, i_extend_valid, i_rd_data0, i_rd_data1,
    input  o_rd_addr0, o_rd_addr1, o_ready, o_hash, o_hash_valid
  );

  modport slave (
    input  i_start, i_first, i_extend_valid, i_rd_data0, i_rd_data1,
    output o_rd_addr0, o_rd_addr1, o_ready, o_hash, o_hash_valid
  );
endinterface

// File: rtl/sm3_compress.sv
// ---------------------------------------------------------------------------
// sm3_compress
//   SM3 compression function CF. On an accepted start it reads W_j / W'_j
//   (j = 0..63) from the expansion stage, runs the 64 rounds and produces
//   V(i+1) = CF(V(i), B(i)). A first block chains from the SM3 IV instead of
//   the previous result. The value left on o_hash after the last block is
//   the digest.
//
//   Ports:
//     i_clk  clock
//     i_rst  synchronous active-high reset
//     bus    sm3_compress_if.slave (handshake, read port, hash result)
//
//   Parameters:
//     W_PRIME_BASE  address of W'_0 in the expansion stage
//     ADDR_W        read address width
//
//   Build option:
//     SM3_CF_TWO_CYCLE_ROUND_EN  split every round into two cycles
//       (ROUND computes and registers TT1/TT2, ROUND_B updates A..H),
//       giving a shorter critical path and start-to-valid latency 130
//       instead of 66.
// ---------------------------------------------------------------------------
module sm3_compress #(
  parameter int W_PRIME_BASE = 68,
  parameter int ADDR_W       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sm3_compress_if.slave bus
);

  localparam logic [255:0] IV = {32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
                                 32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};
  localparam logic [31:0]  T_LO = 32'h79cc4519;
  localparam logic [31:0]  T_HI = 32'h7a879d8a;

  // ROUND_B is only entered when rounds are split over two cycles
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, ROUND_B, FINAL} state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    // a zero rotate shifts the right half out completely, leaving x
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  j_q, j_d;
  logic [31:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0] a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic        first_q, first_d;
  logic [255:0] hash_q, hash_d;
  logic        valid_q, valid_d;
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
  logic [31:0] tt1_q, tt1_d, tt2_q, tt2_d;
`endif

  logic [31:0] a12, tj, ffv, ggv, ss1, ss2, tt1, tt2;
  logic [31:0] updTt1, updTt2;
  logic        doUpdate;
  logic        inRound;
  logic [255:0] vIn;

  // The chaining value is never stored separately: o_hash only changes in
  // FINAL, so during a block it still holds V(i) unless this is a first block.
  assign vIn = first_q ? IV : hash_q;

  // Round arithmetic for the current j, fed by the combinational read data
  always_comb begin
    a12 = rotl(a_q, 5'd12);
    if (j_q < 6'd16) begin
      tj  = T_LO;
      ffv = a_q ^ b_q ^ c_q;
      ggv = e_q ^ f_q ^ g_q;
    end else begin
      tj  = T_HI;
      ffv = (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
      ggv = (e_q & f_q) | (~e_q & g_q);
    end
    ss1 = rotl(a12 + e_q + rotl(tj, j_q[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    tt1 = ffv + d_q + ss2 + bus.i_rd_data1;
    tt2 = ggv + h_q + ss1 + bus.i_rd_data0;
  end

  // In the split build SS1/SS2 only feed TT1/TT2, so holding the two sums
  // is enough for the second cycle
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
  assign updTt1 = tt1_q;
  assign updTt2 = tt2_q;
`else
  assign updTt1 = tt1;
  assign updTt2 = tt2;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
    first_d  = first_q;
    hash_d   = hash_q;
    valid_d  = 1'b0;
    doUpdate = 1'b0;
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
    tt1_d = tt1_q;
    tt2_d = tt2_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_start && bus.i_extend_valid) begin
          first_d = bus.i_first;
          state_d = LOAD;
        end
      end
      LOAD: begin
        {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = vIn;
        j_d     = 6'd0;
        state_d = ROUND;
      end
      ROUND: begin
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
        tt1_d   = tt1;
        tt2_d   = tt2;
        state_d = ROUND_B;
`else
        doUpdate = 1'b1;
`endif
      end
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
      ROUND_B: begin
        doUpdate = 1'b1;
        state_d  = ROUND;
      end
`endif
      FINAL: begin
        hash_d  = vIn ^ {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared register rotation at the end of each round
    if (doUpdate) begin
      d_d = c_q;
      c_d = rotl(b_q, 5'd9);
      b_d = a_q;
      a_d = updTt1;
      h_d = g_q;
      g_d = rotl(f_q, 5'd19);
      f_d = e_q;
      e_d = p0(updTt2);
      j_d = j_q + 6'd1;
      if (j_q == 6'd63) begin
        state_d = FINAL;
      end
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      j_q     <= 6'd0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      first_q <= 1'b0;
      hash_q  <= IV;
      valid_q <= 1'b0;
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
      tt1_q <= '0;
      tt2_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
      first_q <= first_d;
      hash_q  <= hash_d;
      valid_q <= valid_d;
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
      tt1_q <= tt1_d;
      tt2_q <= tt2_d;
`endif
    end
  end

  // Addresses follow j only while rounds run, otherwise sit at the reset values
  assign inRound        = (state_q == ROUND) || (state_q == ROUND_B);
  assign bus.o_rd_addr0 = inRound ? ADDR_W'(j_q) : '0;
  assign bus.o_rd_addr1 = inRound ? ADDR_W'(W_PRIME_BASE + int'(j_q)) : ADDR_W'(W_PRIME_BASE);
  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_hash     = hash_q;
  assign bus.o_hash_valid = valid_q;

endmodule

// File: tb/tb_sm3_compress.sv
// ---------------------------------------------------------------------------
// tb_sm3_compress
//   Bench for sm3_compress. An expansion-stage model answers the read port,
//   a block-level SM3 CF model predicts every digest, and a cycle model of
//   the start/latency behaviour predicts ready, valid, hash and read
//   addresses on every cycle. Known SM3 digests pin the model.
//   Define SM3_CF_TWO_CYCLE_ROUND_EN for both bench and RTL to run the
//   split-round build.
// ---------------------------------------------------------------------------
module tb_sm3_compress;

  localparam int W_PRIME_BASE = 68;
  localparam int ADDR_W       = 8;
`ifdef SM3_CF_TWO_CYCLE_ROUND_EN
  localparam int RCYC = 2;
`else
  localparam int RCYC = 1;
`endif
  localparam int LAT = 2 + 64 * RCYC;

  localparam logic [255:0] IV = {32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
                                 32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};
  localparam logic [255:0] ABC_DIGEST = {32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                                         32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
  localparam logic [255:0] ABCD_DIGEST = {32'hdebe9ff9, 32'h2275b8a1, 32'h38604889, 32'hc18e5a4d,
                                          32'h6fdb70e5, 32'h387e5765, 32'h293dcba3, 32'h9c0c5732};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ABCD1_BLK = {16{32'h61626364}};
  localparam logic [511:0] ABCD2_BLK = {32'h80000000, 448'h0, 32'h00000200};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm3_compress_if #(.ADDR_W(ADDR_W)) bus ();

  sm3_compress #(.W_PRIME_BASE(W_PRIME_BASE), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // Expansion-stage storage, read combinationally
  logic [31:0]  mem [256];
  logic [511:0] curBlock;
  assign bus.i_rd_data0 = mem[bus.o_rd_addr0];
  assign bus.i_rd_data1 = mem[bus.o_rd_addr1];

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit checkEn  = 1'b0;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  function automatic logic [31:0] expandWord(input logic [511:0] blk, input int idx);
    logic [31:0] w [68];
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 68; i++)
      w[i] = p1(w[i-16] ^ w[i-9] ^ rotl(w[i-3], 15)) ^ rotl(w[i-13], 7) ^ w[i-6];
    if (idx < 68) return w[idx];
    return w[idx - 68] ^ w[idx - 64];
  endfunction

  // Full SM3 CF on one block, straight from the algorithm definition
  function automatic logic [255:0] cfModel(input logic [255:0] v, input logic [511:0] blk);
    logic [31:0] w [68];
    logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2, ff, gg;
    for (int i = 0; i < 68; i++) w[i] = expandWord(blk, i);
    {a, b, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rotl(rotl(a, 12) + e + rotl(t, j), 7);
      ss2 = ss1 ^ rotl(a, 12);
      ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + (w[j] ^ w[j+4]);
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rotl(b, 9); b = a; a = tt1;
      h = g; g = rotl(f, 19); f = e; e = p0(tt2);
    end
    return v ^ {a, b, c, d, e, f, g, h};
  endfunction

  task automatic loadBlock(input logic [511:0] blk);
    curBlock = blk;
    for (int i = 0; i < 132; i++) mem[i] = expandWord(blk, i);
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs starting now (caller sits on a negedge)
  task automatic applyStimulus(input logic start, input logic first, input logic extValid);
    bus.i_start        = start;
    bus.i_first        = first;
    bus.i_extend_valid = extValid;
    @(negedge clk);
    bus.i_start        = 1'b0;
    bus.i_first        = 1'b0;
    bus.i_extend_valid = 1'b1;
  endtask

  task automatic waitPulse(input string name, output int lat);
    lat = 0;
    while (bus.o_hash_valid !== 1'b1 && lat < LAT + 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, " pulse seen"}, {255'b0, bus.o_hash_valid}, 256'd1);
  endtask

  // Cycle model: accepted starts, busy window, result publication
  bit           mBusy = 1'b0;
  int           mCnt  = 0;
  logic [255:0] mHash = IV;
  logic [255:0] mPending = '0;
  bit           mValid = 1'b0;

  always @(posedge clk) begin
    mValid <= 1'b0;
    if (rst) begin
      mBusy <= 1'b0;
      mCnt  <= 0;
      mHash <= IV;
    end else if (mBusy) begin
      mCnt <= mCnt + 1;
      if (mCnt + 1 == LAT) begin
        mBusy  <= 1'b0;
        mHash  <= mPending;
        mValid <= 1'b1;
      end
    end else if (bus.i_start && bus.i_extend_valid) begin
      mBusy    <= 1'b1;
      mCnt     <= 0;
      mPending <= cfModel(bus.i_first ? IV : mHash, curBlock);
    end
  end

  // Per-cycle comparison of every output against the cycle model
  always @(negedge clk) begin
    int expA0, expA1;
    if (checkEn) begin
      expA0 = 0;
      expA1 = W_PRIME_BASE;
      if (mBusy && mCnt >= 1 && mCnt <= 64 * RCYC) begin
        expA0 = (mCnt - 1) / RCYC;
        expA1 = W_PRIME_BASE + expA0;
      end
      checkOutput("cyc ready", {255'b0, bus.o_ready}, {255'b0, !mBusy});
      checkOutput("cyc hash_valid", {255'b0, bus.o_hash_valid}, {255'b0, mValid});
      checkOutput("cyc hash", bus.o_hash, mHash);
      checkOutput("cyc rd_addr0", {248'b0, bus.o_rd_addr0}, 256'(expA0));
      checkOutput("cyc rd_addr1", {248'b0, bus.o_rd_addr1}, 256'(expA1));
      if (bus.o_hash_valid === 1'b1) pulses++;
    end
  end

  initial begin
    int lat;
    int p0Cnt;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    curBlock           = ABC_BLK;
    bus.i_start        = 1'b0;
    bus.i_first        = 1'b0;
    bus.i_extend_valid = 1'b1;
    rst                = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset hash", bus.o_hash, IV);
    checkOutput("reset ready", {255'b0, bus.o_ready}, 256'd1);
    checkOutput("reset rd_addr1", {248'b0, bus.o_rd_addr1}, 256'd68);
    rst = 1'b0;
    @(negedge clk);

    // "abc" single block from IV
    loadBlock(ABC_BLK);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitPulse("abc", lat);
    checkOutput("abc latency", 256'(lat), 256'(LAT));
    checkOutput("abc digest", bus.o_hash, ABC_DIGEST);

    // chained "abc" block started on the pulse cycle, not IV based
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitPulse("abc chained", lat);
    checkOutput("abc chained digest", bus.o_hash, cfModel(ABC_DIGEST, ABC_BLK));

    // "abcd" x16, two blocks back to back, with address spot checks
    @(negedge clk);
    loadBlock(ABCD1_BLK);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("first round rd_addr0", {248'b0, bus.o_rd_addr0}, 256'd0);
    checkOutput("first round rd_addr1", {248'b0, bus.o_rd_addr1}, 256'd68);
    repeat (64 * RCYC - 1) @(negedge clk);
    checkOutput("last round rd_addr0", {248'b0, bus.o_rd_addr0}, 256'd63);
    checkOutput("last round rd_addr1", {248'b0, bus.o_rd_addr1}, 256'd131);
    waitPulse("abcd block1", lat);
    loadBlock(ABCD2_BLK);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitPulse("abcd block2", lat);
    checkOutput("abcd block2 latency", 256'(lat), 256'(LAT));
    checkOutput("abcd digest", bus.o_hash, ABCD_DIGEST);

    // start without extend_valid is ignored, start during rounds too
    @(negedge clk);
    p0Cnt = pulses;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("no start without extend_valid", 256'(pulses - p0Cnt), 256'd0);
    checkOutput("hash held while idle", bus.o_hash, ABCD_DIGEST);
    loadBlock(ABC_BLK);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (10 * RCYC + 1) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitPulse("abc with mid-round start", lat);
    repeat (5) @(negedge clk);
    checkOutput("single pulse", 256'(pulses - p0Cnt), 256'd1);
    checkOutput("digest after ignored start", bus.o_hash, ABC_DIGEST);

    // reset during round 30 aborts the block without a pulse
    p0Cnt = pulses;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (30 * RCYC + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("hash after abort reset", bus.o_hash, IV);
    checkOutput("ready after abort reset", {255'b0, bus.o_ready}, 256'd1);
    repeat (LAT + 5) @(negedge clk);
    checkOutput("no pulse from aborted run", 256'(pulses - p0Cnt), 256'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitPulse("abc rerun", lat);
    checkOutput("abc rerun digest", bus.o_hash, ABC_DIGEST);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound so the run always ends
  initial begin
    #(400000);
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
